// File: rtl/day2_range_scheduler.sv
// Range scheduler for the day2 checker: buffers ID ranges in a small FIFO, deals them
// round-robin to a pool of idle workers and accumulates their partial invalid-ID sums.
module day2_range_scheduler #(
    parameter int W           = 48,
    parameter int NUM_WORKERS = 4,
    parameter int DEPTH       = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_start,
    input  logic [W-1:0]             in_end,
    input  logic                     in_last,
    output logic [NUM_WORKERS-1:0]   wk_start,
    output logic [W-1:0]             wk_start_id,
    output logic [W-1:0]             wk_end_id,
    input  logic [NUM_WORKERS-1:0]   wk_done,
    input  logic [NUM_WORKERS*W-1:0] wk_sum,
    output logic [W-1:0]             id_sum,
    output logic                     done,
    output logic                     overflow,
    output logic                     err
);

    localparam int PW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    // Wide enough for the running sum plus every worker reporting on the same edge.
    localparam int SW = W + $clog2(NUM_WORKERS + 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   alive_q;
    logic [W-1:0]           fifoStart_q [DEPTH];
    logic [W-1:0]           fifoEnd_q   [DEPTH];
    logic [AW-1:0]          wrPtr_q, wrPtr_d;
    logic [AW-1:0]          rdPtr_q, rdPtr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [NUM_WORKERS-1:0] busy_q, busy_d;
    logic [PW-1:0]          rr_q, rr_d;
    logic [NUM_WORKERS-1:0] wkStart_q, wkStart_d;
    logic [W-1:0]           startId_q, startId_d;
    logic [W-1:0]           endId_q, endId_d;
    logic [W-1:0]           idSum_q, idSum_d;
    logic                   overflow_q, overflow_d;
    logic                   err_q, err_d;

    logic                   fifoEmpty;
    logic                   fifoFull;
    logic                   accept;
    logic                   badRange;
    logic                   push;
    logic                   grant;
    logic                   grantFound;
    logic [PW-1:0]          grantIdx;
    logic [PW-1:0]          candIdx;
    logic [NUM_WORKERS-1:0] grantVec;
    logic [NUM_WORKERS-1:0] doneOk;
    logic [NUM_WORKERS-1:0] doneBad;
    logic [SW-1:0]          sumExt;

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == CW'(DEPTH));
    assign in_ready  = alive_q && (state_q == RUN) && !fifoFull;
    assign accept    = in_valid && in_ready;
    assign badRange  = (in_start > in_end);
    assign push      = accept && !badRange && !clear;
    assign doneOk    = wk_done & busy_q;
    assign doneBad   = wk_done & ~busy_q;
    assign grant     = grantFound && !fifoEmpty && !clear;

    // First idle worker at or after the round-robin pointer.
    always_comb begin
        grantVec   = '0;
        grantIdx   = '0;
        grantFound = 1'b0;
        candIdx    = '0;
        for (int off = 0; off < NUM_WORKERS; off++) begin
            candIdx = PW'((int'(rr_q) + off) % NUM_WORKERS);
            if (!grantFound && !busy_q[candIdx]) begin
                grantFound         = 1'b1;
                grantIdx           = candIdx;
                grantVec[candIdx]  = 1'b1;
            end
        end
    end

    always_comb begin
        sumExt = SW'(idSum_q);
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (doneOk[i]) begin
                sumExt = sumExt + SW'(wk_sum[i*W +: W]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q + CW'(push) - CW'(grant);
        busy_d     = busy_q & ~doneOk;
        rr_d       = rr_q;
        wkStart_d  = '0;
        startId_d  = startId_q;
        endId_d    = endId_q;
        idSum_d    = sumExt[W-1:0];
        overflow_d = overflow_q | (sumExt[SW-1:W] != '0);
        err_d      = err_q | (accept && badRange) | (|doneBad);

        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (grant) begin
            rdPtr_d   = rdPtr_q + 1'b1;
            busy_d    = busy_d | grantVec;
            wkStart_d = grantVec;
            startId_d = fifoStart_q[rdPtr_q];
            endId_d   = fifoEnd_q[rdPtr_q];
            rr_d      = (grantIdx == PW'(NUM_WORKERS - 1)) ? '0 : grantIdx + 1'b1;
        end

        case (state_q)
            RUN: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifoEmpty && (busy_q == '0) && (wk_done == '0)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Busy bits survive a clear so in-flight results land in the next job.
        if (clear) begin
            state_d    = RUN;
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            idSum_d    = '0;
            overflow_d = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            alive_q    <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            rr_q       <= '0;
            wkStart_q  <= '0;
            startId_q  <= '0;
            endId_q    <= '0;
            idSum_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            rr_q       <= rr_d;
            wkStart_q  <= wkStart_d;
            startId_q  <= startId_d;
            endId_q    <= endId_d;
            idSum_q    <= idSum_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifoStart_q[wrPtr_q] <= in_start;
            fifoEnd_q[wrPtr_q]   <= in_end;
        end
    end

    assign wk_start    = wkStart_q;
    assign wk_start_id = startId_q;
    assign wk_end_id   = endId_q;
    assign id_sum      = idSum_q;
    assign done        = (state_q == DONE);
    assign overflow    = overflow_q;
    assign err         = err_q;

endmodule

// File: tb/tb_day2_range_scheduler.sv
// Directed bench for day2_range_scheduler: the bench plays the worker pool by hand
// and compares outputs against hand-computed values.
module tb_day2_range_scheduler;

    localparam int W  = 8;
    localparam int NW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_start;
    logic [W-1:0]    in_end;
    logic            in_last;
    logic [NW-1:0]   wk_start;
    logic [W-1:0]    wk_start_id;
    logic [W-1:0]    wk_end_id;
    logic [NW-1:0]   wk_done;
    logic [NW*W-1:0] wk_sum;
    logic [W-1:0]    id_sum;
    logic            done;
    logic            overflow;
    logic            err;

    int vecCount = 0;
    int errCount = 0;
    logic [NW-1:0] grantLog [$];
    logic [W-1:0]  idLog [$];
    int logSize;

    day2_range_scheduler #(.W(W), .NUM_WORKERS(NW), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_start   (in_start),
        .in_end     (in_end),
        .in_last    (in_last),
        .wk_start   (wk_start),
        .wk_start_id(wk_start_id),
        .wk_end_id  (wk_end_id),
        .wk_done    (wk_done),
        .wk_sum     (wk_sum),
        .id_sum     (id_sum),
        .done       (done),
        .overflow   (overflow),
        .err        (err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wk_start != '0) begin
            grantLog.push_back(wk_start);
            idLog.push_back(wk_start_id);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic resetDut();
        reset = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        clear = 1'b0;
        wk_done = '0;
        wk_sum = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        grantLog.delete();
        idLog.delete();
    endtask

    task automatic applyStimulus(input logic [W-1:0] s, input logic [W-1:0] e,
                                 input logic l);
        int waitCnt;
        waitCnt = 0;
        while (!in_ready && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("ready_wait", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_start = s;
        in_end   = e;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulseDone(input logic [NW-1:0] mask, input logic [NW*W-1:0] sums);
        wk_done = mask;
        wk_sum  = sums;
        tick();
        wk_done = '0;
        wk_sum  = '0;
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_start = '0;
        in_end = '0;
        in_last = 1'b0;
        wk_done = '0;
        wk_sum = '0;
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 0);
        checkOutput("rst_wk_start", 64'(wk_start), 0);
        checkOutput("rst_start_id", 64'(wk_start_id), 0);
        checkOutput("rst_id_sum", 64'(id_sum), 0);
        checkOutput("rst_flags", 64'({done, overflow, err}), 0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rel_in_ready", 64'(in_ready), 1);

        // Single range 11..22 returning 33.
        applyStimulus(8'd11, 8'd22, 1'b1);
        checkOutput("single_no_early_start", 64'(wk_start), 0);
        tick();
        checkOutput("single_wk_start", 64'(wk_start), 64'b0001);
        checkOutput("single_start_id", 64'(wk_start_id), 11);
        checkOutput("single_end_id", 64'(wk_end_id), 22);
        tick();
        checkOutput("single_pulse_len", 64'(wk_start), 0);
        checkOutput("single_bus_hold", 64'(wk_end_id), 22);
        repeat (3) tick();
        pulseDone(4'b0001, 32'd33);
        checkOutput("single_sum", 64'(id_sum), 33);
        checkOutput("single_not_done_yet", 64'(done), 0);
        tick();
        checkOutput("single_done", 64'(done), 1);
        checkOutput("single_flags", 64'({overflow, err}), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear_sum", 64'(id_sum), 0);
        checkOutput("clear_done", 64'(done), 0);
        checkOutput("clear_ready", 64'(in_ready), 1);

        // Round-robin with eight back-to-back ranges; workers hold until released.
        resetDut();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(8'(10*k + 1), 8'(10*k + 5), 1'b0);
        end
        checkOutput("rr_full_ready", 64'(in_ready), 0);
        checkOutput("rr_count", 64'(grantLog.size()), 4);
        for (int k = 0; k < 4 && k < grantLog.size(); k++) begin
            checkOutput($sformatf("rr_grant%0d", k), 64'(grantLog[k]), 64'(1 << k));
            checkOutput($sformatf("rr_id%0d", k), 64'(idLog[k]), 64'(10*k + 1));
        end
        pulseDone(4'b0100, {8'd0, 8'd5, 8'd0, 8'd0});
        checkOutput("rr_w2_sum", 64'(id_sum), 5);
        tick();
        checkOutput("rr_regrant_w2", 64'(wk_start), 64'b0100);
        checkOutput("rr_regrant_w2_id", 64'(wk_start_id), 41);
        checkOutput("rr_ready_again", 64'(in_ready), 1);
        pulseDone(4'b0001, {8'd0, 8'd0, 8'd0, 8'd7});
        checkOutput("rr_w0_sum", 64'(id_sum), 12);
        tick();
        checkOutput("rr_regrant_w0", 64'(wk_start), 64'b0001);
        checkOutput("rr_regrant_w0_id", 64'(wk_start_id), 51);

        // All four workers report on one edge.
        pulseDone(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1});
        checkOutput("simul_sum", 64'(id_sum), 22);
        checkOutput("simul_no_grant_same_edge", 64'(wk_start), 0);
        tick();
        checkOutput("simul_next_grant", 64'(wk_start), 64'b0010);
        checkOutput("simul_next_id", 64'(wk_start_id), 61);
        tick();
        checkOutput("simul_second_grant", 64'(wk_start), 64'b0100);
        checkOutput("simul_ovf", 64'(overflow), 0);

        // Spurious completion from idle worker 3.
        pulseDone(4'b1000, {8'd99, 8'd0, 8'd0, 8'd0});
        checkOutput("spur_err", 64'(err), 1);
        checkOutput("spur_sum", 64'(id_sum), 22);

        // Overflow with 8-bit sums: 200 + 100 wraps to 44.
        resetDut();
        applyStimulus(8'd1, 8'd2, 1'b0);
        applyStimulus(8'd3, 8'd4, 1'b1);
        tick();
        pulseDone(4'b0001, {8'd0, 8'd0, 8'd0, 8'd200});
        checkOutput("ovf_first", 64'(id_sum), 200);
        checkOutput("ovf_first_flag", 64'(overflow), 0);
        pulseDone(4'b0010, {8'd0, 8'd0, 8'd100, 8'd0});
        checkOutput("ovf_sum", 64'(id_sum), 44);
        checkOutput("ovf_flag", 64'(overflow), 1);
        tick();
        checkOutput("ovf_done", 64'(done), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("ovf_clear_flag", 64'(overflow), 0);
        checkOutput("ovf_clear_ready", 64'(in_ready), 1);

        // Reversed range as the only, final range.
        resetDut();
        applyStimulus(8'd30, 8'd20, 1'b1);
        checkOutput("bad_err", 64'(err), 1);
        checkOutput("bad_drain_ready", 64'(in_ready), 0);
        checkOutput("bad_not_done", 64'(done), 0);
        tick();
        checkOutput("bad_done", 64'(done), 1);
        checkOutput("bad_sum", 64'(id_sum), 0);
        checkOutput("bad_no_dispatch", 64'(grantLog.size()), 0);

        // Reset asserted mid-job while a start pulse is on the bus.
        resetDut();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(8'(k + 1), 8'(k + 2), 1'b0);
        end
        pulseDone(4'b0010, {8'd0, 8'd0, 8'd9, 8'd0});
        checkOutput("mid_sum", 64'(id_sum), 9);
        tick();
        checkOutput("mid_grant", 64'(wk_start), 64'b0010);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_wk_start", 64'(wk_start), 0);
        checkOutput("mid_rst_ready", 64'(in_ready), 0);
        checkOutput("mid_rst_sum", 64'(id_sum), 0);
        checkOutput("mid_rst_bus", 64'(wk_start_id), 0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("mid_rel_ready", 64'(in_ready), 1);
        logSize = grantLog.size();
        repeat (3) tick();
        checkOutput("mid_fifo_flushed", 64'(grantLog.size()), 64'(logSize));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
